// File: rtl/hsv_frame_rx.sv
// Serial HSV pixel receiver: samples the Pi's clock/data lines, thresholds each pixel to a
// hand bit and delivers double-buffered ROWS x COLS binary frames over a valid/ready handshake.
module hsv_frame_rx #(
   parameter int unsigned ROWS           = 16,
   parameter int unsigned COLS           = 16,
   parameter int unsigned BITS_PER_PX    = 24,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned SAMPLE_DIV     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter bit          MSB_FIRST      = 1'b0
) (
   input  logic                               fpga_clk,
   input  logic                               rst_n,
   input  logic                               pi_clk,
   input  logic                               data_in,
   input  logic [BITS_PER_PX/3-1:0]           min_hue,
   input  logic [BITS_PER_PX/3-1:0]           max_hue,
   input  logic [BITS_PER_PX/3-1:0]           min_sat,
   input  logic [BITS_PER_PX/3-1:0]           min_val,
   output logic [ROWS*COLS-1:0]               frame,
   output logic                               frame_valid,
   input  logic                               frame_ready,
   output logic [$clog2(ROWS*COLS+1)-1:0]     pixel_count,
   output logic                               busy,
   output logic                               overrun,
   output logic                               resync
);

   localparam int unsigned CH_W  = BITS_PER_PX / 3;
   localparam int unsigned NPIX  = ROWS * COLS;
   localparam int unsigned PC_W  = $clog2(NPIX + 1);
   localparam int unsigned IDX_W = $clog2(NPIX);
   localparam int unsigned BC_W  = $clog2(BITS_PER_PX);
   localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic [DIV_W-1:0]       div_q;
   logic                   s_clk_q;
   logic [BC_W-1:0]        bit_cnt_q;
   logic [BITS_PER_PX-1:0] pix_q;
   logic [NPIX-1:0]        work_q;
   logic [PC_W-1:0]        pixel_count_q;
   logic [TO_W-1:0]        idle_q;
   logic [NPIX-1:0]        frame_q;
   logic                   frame_valid_q;
   logic                   overrun_q;
   logic                   resync_q;

   logic                   strobe_c;
   logic                   edge_c;
   logic                   last_bit_c;
   logic                   frame_done_c;
   logic [BC_W-1:0]        bit_idx_c;
   logic [BITS_PER_PX-1:0] pix_c;
   logic [CH_W-1:0]        hue_c;
   logic [CH_W-1:0]        sat_c;
   logic [CH_W-1:0]        val_c;
   logic                   hand_c;
   logic [NPIX-1:0]        work_c;

   // A rising pi_clk is only recognised on a sample strobe, against the previous sampled level.
   assign strobe_c     = (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign edge_c       = strobe_c && !s_clk_q && clk_sync_q[SYNC_STAGES-1];
   assign last_bit_c   = edge_c && (bit_cnt_q == BC_W'(BITS_PER_PX - 1));
   assign frame_done_c = last_bit_c && (pixel_count_q == PC_W'(NPIX - 1));
   assign bit_idx_c    = MSB_FIRST ? (BC_W'(BITS_PER_PX - 1) - bit_cnt_q) : bit_cnt_q;

   // Pixel including the bit captured on this strobe.
   always_comb begin
      pix_c            = pix_q;
      pix_c[bit_idx_c] = dat_sync_q[SYNC_STAGES-1];
   end

   assign hue_c  = pix_c[CH_W-1:0];
   assign sat_c  = pix_c[2*CH_W-1:CH_W];
   assign val_c  = pix_c[3*CH_W-1:2*CH_W];
   assign hand_c = !((hue_c >= min_hue) && (hue_c <= max_hue) &&
                     (sat_c >= min_sat) && (val_c >= min_val));

   always_comb begin
      work_c                           = work_q;
      work_c[IDX_W'(pixel_count_q)]    = hand_c;
   end

   always_ff @(posedge fpga_clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         clk_sync_q    <= '0;
         dat_sync_q    <= '0;
         div_q         <= '0;
         s_clk_q       <= 1'b0;
         bit_cnt_q     <= '0;
         pix_q         <= '0;
         work_q        <= '0;
         pixel_count_q <= '0;
         idle_q        <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         resync_q      <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], pi_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data_in};
         div_q      <= strobe_c ? '0 : div_q + DIV_W'(1);
         if (strobe_c) begin
            s_clk_q <= clk_sync_q[SYNC_STAGES-1];
         end
         resync_q <= 1'b0;
         if (frame_valid_q && frame_ready) begin
            frame_valid_q <= 1'b0;
         end

         if (edge_c) begin
            idle_q  <= '0;
            state_q <= RECV;
            if (last_bit_c) begin
               bit_cnt_q <= '0;
               pix_q     <= '0;
               if (frame_done_c) begin
                  work_q        <= '0;
                  pixel_count_q <= '0;
                  state_q       <= IDLE;
                  // A held frame that is not being consumed right now wins over the new one.
                  if (!frame_valid_q || frame_ready) begin
                     frame_q       <= work_c;
                     frame_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else begin
                  work_q        <= work_c;
                  pixel_count_q <= pixel_count_q + PC_W'(1);
               end
            end else begin
               bit_cnt_q <= bit_cnt_q + BC_W'(1);
               pix_q     <= pix_c;
            end
         end else if (state_q == RECV) begin
            if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               idle_q        <= '0;
               bit_cnt_q     <= '0;
               pix_q         <= '0;
               work_q        <= '0;
               pixel_count_q <= '0;
               resync_q      <= 1'b1;
               state_q       <= IDLE;
            end else begin
               idle_q <= idle_q + TO_W'(1);
            end
         end
      end
   end

   assign frame       = frame_q;
   assign frame_valid = frame_valid_q;
   assign pixel_count = pixel_count_q;
   assign busy        = (state_q == RECV);
   assign overrun     = overrun_q;
   assign resync      = resync_q;

endmodule

// File: tb/tb_hsv_frame_rx.sv
// Bench for hsv_frame_rx: bit-level serial stimulus against a pixel/frame-level reference model,
// with LSB-first and MSB-first instances sharing one stimulus path.
module tb_hsv_frame_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0, pi_clk = 1'b0, data_in = 1'b0, frame_ready = 1'b0, sel = 1'b0;
   logic [7:0] min_hue = '0, max_hue = '0, min_sat = '0, min_val = '0;

   logic        pc0, dt0, rd0, pc1, dt1, rd1;
   logic [15:0] fr0, fr1, d_frame;
   logic [4:0]  pn0, pn1, d_pcnt;
   logic        fv0, fv1, bz0, bz1, ov0, ov1, rs0, rs1;
   logic        d_fv, d_busy, d_ovr, d_rs;

   assign pc0 = sel ? 1'b0 : pi_clk;
   assign dt0 = sel ? 1'b0 : data_in;
   assign rd0 = sel ? 1'b0 : frame_ready;
   assign pc1 = sel ? pi_clk : 1'b0;
   assign dt1 = sel ? data_in : 1'b0;
   assign rd1 = sel ? frame_ready : 1'b0;

   hsv_frame_rx #(.ROWS(4), .COLS(4), .BITS_PER_PX(24), .SYNC_STAGES(2), .SAMPLE_DIV(4),
                  .TIMEOUT_CYCLES(200), .MSB_FIRST(1'b0)) dut_lsb (
      .fpga_clk(clk), .rst_n(rst_n), .pi_clk(pc0), .data_in(dt0),
      .min_hue(min_hue), .max_hue(max_hue), .min_sat(min_sat), .min_val(min_val),
      .frame(fr0), .frame_valid(fv0), .frame_ready(rd0), .pixel_count(pn0),
      .busy(bz0), .overrun(ov0), .resync(rs0));

   hsv_frame_rx #(.ROWS(4), .COLS(4), .BITS_PER_PX(24), .SYNC_STAGES(2), .SAMPLE_DIV(4),
                  .TIMEOUT_CYCLES(200), .MSB_FIRST(1'b1)) dut_msb (
      .fpga_clk(clk), .rst_n(rst_n), .pi_clk(pc1), .data_in(dt1),
      .min_hue(min_hue), .max_hue(max_hue), .min_sat(min_sat), .min_val(min_val),
      .frame(fr1), .frame_valid(fv1), .frame_ready(rd1), .pixel_count(pn1),
      .busy(bz1), .overrun(ov1), .resync(rs1));

   assign d_frame = sel ? fr1 : fr0;
   assign d_fv    = sel ? fv1 : fv0;
   assign d_pcnt  = sel ? pn1 : pn0;
   assign d_busy  = sel ? bz1 : bz0;
   assign d_ovr   = sel ? ov1 : ov0;
   assign d_rs    = sel ? rs1 : rs0;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: frame-level state plus progress counters of the frame in flight.
   logic [15:0] m_frame = '0, m_work = '0;
   logic        m_valid = 1'b0, m_ovr = 1'b0;
   int          m_px = 0, m_bits = 0;
   logic        chk_en = 1'b0;
   logic [23:0] fpx [16];

   int rs_cnt = 0, rs_wide = 0, vrise_cyc = 0, last_rise_cyc = 0;
   logic rs_prev = 1'b0, fv_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("frame",       32'(d_frame), 32'(m_frame));
         check("frame_valid", 32'(d_fv),    32'(m_valid));
         check("overrun",     32'(d_ovr),   32'(m_ovr));
         check("busy",        32'(d_busy),  32'((m_px != 0) || (m_bits != 0)));
         check("pixel_count", 32'(d_pcnt),  32'(m_px));
         check("resync_idle", 32'(d_rs),    32'd0);
      end
      if (d_rs) rs_cnt++;
      if (d_rs && rs_prev) rs_wide++;
      if (d_fv && !fv_prev) vrise_cyc = cyc;
      rs_prev = d_rs;
      fv_prev = d_fv;
   end

   function automatic logic hand_of(input logic [23:0] p);
      int hue, sat, val;
      hue = int'(p[7:0]);
      sat = int'(p[15:8]);
      val = int'(p[23:16]);
      return !((hue >= int'(min_hue)) && (hue <= int'(max_hue)) &&
               (sat >= int'(min_sat)) && (val >= int'(min_val)));
   endfunction

   task automatic model_pixel(input logic [23:0] p, input logic rdy);
      m_work[m_px] = hand_of(p);
      m_px++;
      m_bits = 0;
      if (m_px == 16) begin
         m_px = 0;
         if (!m_valid || rdy) begin
            m_frame = m_work;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
         m_work = '0;
      end
   endtask

   task automatic model_reset();
      m_frame = '0; m_work = '0; m_valid = 1'b0; m_ovr = 1'b0; m_px = 0; m_bits = 0;
   endtask

   // Runs n cycles from a point just after a posedge; checks in the last two, settled cycles.
   task automatic wait_chk(input int n, input int rdy_at);
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         chk_en      = (i >= n - 2) && (i < n);
         frame_ready = (i == rdy_at);
      end
   endtask

   task automatic half(input logic c, input logic d, input int rdy_at);
      pi_clk  = c;
      data_in = d;
      wait_chk(8, rdy_at);
   endtask

   task automatic rand_thr();
      min_hue = 8'($urandom_range(0, 120));
      max_hue = 8'($urandom_range(60, 255));
      min_sat = 8'($urandom_range(0, 150));
      min_val = 8'($urandom_range(0, 150));
   endtask

   task automatic send_pixel(input logic [23:0] p, input logic msb, input int rdy_at,
                             input logic chg);
      for (int i = 0; i < 24; i++) begin
         logic b;
         b = msb ? p[23 - i] : p[i];
         if (chg && i == 12) rand_thr();
         half(1'b0, b, -1);
         last_rise_cyc = cyc;
         m_bits++;
         if (m_bits == 24) model_pixel(p, rdy_at >= 0);
         half(1'b1, b, (i == 23) ? rdy_at : -1);
      end
   endtask

   task automatic send_frame(input logic msb, input int rdy_at, input logic chg);
      for (int k = 0; k < 16; k++) send_pixel(fpx[k], msb, (k == 15) ? rdy_at : -1, chg);
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = 1'($urandom);
         half(1'b0, b, -1);
         m_bits++;
         half(1'b1, b, -1);
      end
   endtask

   task automatic set_alt(input logic hand_first);
      for (int k = 0; k < 16; k++)
         fpx[k] = (((k % 2) == 1) ^ hand_first) ? 24'h604030 : 24'h604010;
   endtask

   task automatic set_rand();
      for (int k = 0; k < 16; k++) fpx[k] = 24'($urandom);
   endtask

   task automatic set_thr_t2();
      min_hue = 8'd0; max_hue = 8'd20; min_sat = 8'd48; min_val = 8'd80;
   endtask

   task automatic accept();
      frame_ready = 1'b1;
      m_valid     = 1'b0;
      wait_chk(4, -1);
   endtask

   task automatic do_reset();
      pi_clk = 1'b0; data_in = 1'b0; frame_ready = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      wait_chk(8, -1);
      rst_n = 1'b1;
      wait_chk(8, -1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: run exceeded its time budget after %0d checks", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rs_before;

      // Reset with toggling inputs, then quiet release.
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         pi_clk      = 1'($urandom);
         data_in     = 1'($urandom);
         frame_ready = 1'($urandom);
         chk_en      = (i >= 2);
      end
      chk_en = 1'b0; pi_clk = 1'b0; data_in = 1'b0; frame_ready = 1'b0;
      wait_chk(4, -1);
      rst_n = 1'b1;
      wait_chk(40, -1);

      // Alternating pattern with fixed thresholds.
      set_thr_t2();
      set_alt(1'b0);
      send_frame(1'b0, -1, 1'b0);
      lat = vrise_cyc - last_rise_cyc;
      check("t2_model_frame", 32'(m_frame), 32'h0000AAAA);
      check("t2_frame",       32'(d_frame), 32'h0000AAAA);
      check("t2_valid",       32'(d_fv),    32'd1);
      check("t2_pcnt",        32'(d_pcnt),  32'd0);
      check("t2_busy",        32'(d_busy),  32'd0);
      check("t2_latency",     32'((lat >= 3) && (lat <= 6)), 32'd1);
      accept();

      // Two frames without a consumer: second is dropped.
      send_frame(1'b0, -1, 1'b0);
      set_alt(1'b1);
      send_frame(1'b0, -1, 1'b0);
      check("t3_frame",   32'(d_frame), 32'h0000AAAA);
      check("t3_overrun", 32'(d_ovr),   32'd1);
      check("t3_valid",   32'(d_fv),    32'd1);
      accept();
      check("t3_valid_after_ready", 32'(d_fv), 32'd0);

      // Completion coinciding with frame_ready.
      do_reset();
      set_alt(1'b0);
      send_frame(1'b0, -1, 1'b0);
      lat = vrise_cyc - last_rise_cyc;
      set_alt(1'b1);
      send_frame(1'b0, lat - 1, 1'b0);
      check("t4_frame",   32'(d_frame), 32'h00005555);
      check("t4_valid",   32'(d_fv),    32'd1);
      check("t4_overrun", 32'(d_ovr),   32'd0);

      // Partial frame abandoned by timeout, then clean frames.
      rs_before = rs_cnt;
      send_bits(10);
      m_bits = 0;
      wait_chk(232, -1);
      check("t5_resync_pulses", 32'(rs_cnt - rs_before), 32'd1);
      check("t5_resync_width",  32'(rs_wide),            32'd0);
      check("t5_busy",          32'(d_busy),             32'd0);
      accept();
      rand_thr();
      set_rand();
      send_frame(1'b0, -1, 1'b1);
      check("t5_valid", 32'(d_fv), 32'd1);
      accept();
      min_hue = 8'd200; max_hue = 8'd10; min_sat = 8'd0; min_val = 8'd0;
      set_rand();
      send_frame(1'b0, -1, 1'b0);
      check("t5_inverted_hue", 32'(d_frame), 32'h0000FFFF);

      // MSB-first instance, including a reset in the middle of a pixel.
      sel = 1'b1;
      do_reset();
      set_thr_t2();
      set_alt(1'b0);
      send_frame(1'b1, -1, 1'b0);
      check("t6_frame", 32'(d_frame), 32'h0000AAAA);
      accept();
      send_bits(5);
      do_reset();
      check("t6_pcnt_after_reset", 32'(d_pcnt), 32'd0);
      rand_thr();
      set_rand();
      send_frame(1'b1, -1, 1'b1);
      check("t6_valid", 32'(d_fv), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
